// File: rtl/dcache_req_arbiter.sv
// Round-robin arbiter sharing the HPDC core request port among NUM_REQ requesters.
// Tracks pending tags and their owners to block tag reuse and route responses.
module dcache_req_arbiter #(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned TID_W           = 7,
  parameter int unsigned ADDR_W          = 49,
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NUM_REQ-1:0]                     req_valid_i,
  output logic [NUM_REQ-1:0]                     req_ready_o,
  input  logic [NUM_REQ*TID_W-1:0]               req_tid_i,
  input  logic [NUM_REQ*5-1:0]                   req_op_i,
  input  logic [NUM_REQ*ADDR_W-1:0]              req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]              req_wdata_i,
  input  logic [NUM_REQ*8-1:0]                   req_be_i,
  input  logic [NUM_REQ*2-1:0]                   req_size_i,
  output logic                                   core_req_valid_o,
  input  logic                                   dcache_ready_i,
  output logic [TID_W-1:0]                       dc_tid_o,
  output logic [4:0]                             dc_op_o,
  output logic [ADDR_W-1:0]                      dc_addr_o,
  output logic [DATA_W-1:0]                      dc_wdata_o,
  output logic [7:0]                             dc_be_o,
  output logic [1:0]                             dc_size_o,
  input  logic                                   dcache_valid_i,
  input  logic [TID_W-1:0]                       rsp_tid_i,
  input  logic [DATA_W-1:0]                      rsp_rdata_i,
  output logic [NUM_REQ-1:0]                     resp_valid_o,
  output logic [TID_W-1:0]                       resp_tid_o,
  output logic [DATA_W-1:0]                      resp_data_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   rsp_err_o
);

  localparam int unsigned OW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NTAG = 2 ** TID_W;

  typedef enum logic {ARB, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [IW-1:0]     lock_q, lock_d;
  logic [NTAG-1:0]   pending_q, pending_d;
  logic [OW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     owner_q [NTAG];

  logic [NUM_REQ-1:0] elig;
  logic               full;
  logic               any_gnt;
  logic [IW-1:0]      gnt;
  logic               xfer;
  logic               rsp_hit;

  always_comb begin
    full = (cnt_q == OW'(MAX_OUTSTANDING));
    elig = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid_i[i] && !pending_q[req_tid_i[i*TID_W +: TID_W]] && !full;
    end
  end

  // LOCKED considers only the stalled requester; ARB scans from rr_q with wrap.
  always_comb begin
    int unsigned idx;
    int unsigned nxt;
    idx     = 0;
    nxt     = 0;
    any_gnt = 1'b0;
    gnt     = '0;
    if (state_q == LOCKED) begin
      if (elig[lock_q]) begin
        any_gnt = 1'b1;
        gnt     = lock_q;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = 32'(rr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!any_gnt && elig[IW'(idx)]) begin
          any_gnt = 1'b1;
          gnt     = IW'(idx);
        end
      end
    end

    xfer    = any_gnt && dcache_ready_i;
    state_d = ARB;
    lock_d  = lock_q;
    rr_d    = rr_q;
    nxt     = 32'(gnt) + 1;
    if (nxt >= NUM_REQ) nxt = 0;
    if (xfer) begin
      rr_d = IW'(nxt);
    end else if (any_gnt) begin
      state_d = LOCKED;
      lock_d  = gnt;
    end
  end

  always_comb begin
    core_req_valid_o = any_gnt;
    req_ready_o      = '0;
    dc_tid_o         = req_tid_i[TID_W-1:0];
    dc_op_o          = req_op_i[4:0];
    dc_addr_o        = req_addr_i[ADDR_W-1:0];
    dc_wdata_o       = req_wdata_i[DATA_W-1:0];
    dc_be_o          = req_be_i[7:0];
    dc_size_o        = req_size_i[1:0];
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready_o[i] = xfer && (gnt == IW'(i));
      if (gnt == IW'(i)) begin
        dc_tid_o   = req_tid_i[i*TID_W +: TID_W];
        dc_op_o    = req_op_i[i*5 +: 5];
        dc_addr_o  = req_addr_i[i*ADDR_W +: ADDR_W];
        dc_wdata_o = req_wdata_i[i*DATA_W +: DATA_W];
        dc_be_o    = req_be_i[i*8 +: 8];
        dc_size_o  = req_size_i[i*2 +: 2];
      end
    end
  end

  always_comb begin
    rsp_hit      = dcache_valid_i && pending_q[rsp_tid_i];
    rsp_err_o    = dcache_valid_i && !pending_q[rsp_tid_i];
    resp_tid_o   = rsp_tid_i;
    resp_data_o  = rsp_rdata_i;
    resp_valid_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      resp_valid_o[i] = rsp_hit && (owner_q[rsp_tid_i] == IW'(i));
    end
  end

  // Issue and retire tags can never coincide, so both updates apply independently.
  always_comb begin
    pending_d = pending_q;
    if (xfer)    pending_d[dc_tid_o]  = 1'b1;
    if (rsp_hit) pending_d[rsp_tid_i] = 1'b0;
    cnt_d = cnt_q + OW'(xfer) - OW'(rsp_hit);
  end

  assign outstanding_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ARB;
      rr_q      <= '0;
      lock_q    <= '0;
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned t = 0; t < NTAG; t++) owner_q[t] <= '0;
    end else if (xfer) begin
      owner_q[dc_tid_o] <= gnt;
    end
  end

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Vector-table and scoreboard bench for dcache_req_arbiter (2 requesters, 8 outstanding).
module tb_dcache_req_arbiter;

  localparam int NR = 2;
  localparam int TW = 7;
  localparam int AW = 49;
  localparam int DW = 64;
  localparam int MO = 8;
  localparam int OW = $clog2(MO + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*TW-1:0]  req_tid;
  logic [NR*5-1:0]   req_op;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR*8-1:0]   req_be;
  logic [NR*2-1:0]   req_size;
  logic              core_valid;
  logic              dc_ready;
  logic [TW-1:0]     dc_tid;
  logic [4:0]        dc_op;
  logic [AW-1:0]     dc_addr;
  logic [DW-1:0]     dc_wdata;
  logic [7:0]        dc_be;
  logic [1:0]        dc_size;
  logic              dc_valid;
  logic [TW-1:0]     rsp_tid;
  logic [DW-1:0]     rsp_rdata;
  logic [NR-1:0]     resp_valid;
  logic [TW-1:0]     resp_tid;
  logic [DW-1:0]     resp_data;
  logic [OW-1:0]     outstanding;
  logic              rsp_err;

  always #5 clk = ~clk;

  dcache_req_arbiter #(
    .NUM_REQ(NR), .TID_W(TW), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_tid_i(req_tid), .req_op_i(req_op), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_be_i(req_be), .req_size_i(req_size),
    .core_req_valid_o(core_valid), .dcache_ready_i(dc_ready),
    .dc_tid_o(dc_tid), .dc_op_o(dc_op), .dc_addr_o(dc_addr),
    .dc_wdata_o(dc_wdata), .dc_be_o(dc_be), .dc_size_o(dc_size),
    .dcache_valid_i(dc_valid), .rsp_tid_i(rsp_tid), .rsp_rdata_i(rsp_rdata),
    .resp_valid_o(resp_valid), .resp_tid_o(resp_tid), .resp_data_o(resp_data),
    .outstanding_o(outstanding), .rsp_err_o(rsp_err)
  );

  typedef struct {
    string    name;
    bit       rst;
    bit [1:0] v;
    bit [6:0] t0;
    bit [6:0] t1;
    bit       rdy;
    bit       dv;
    bit [6:0] rt;
    bit       cv;
    bit [1:0] rr;
    bit       eg;
    bit [1:0] rv;
    bit       err;
    int       outs;
  } vec_t;

  typedef struct {
    int       owner;
    bit [6:0] tid;
  } iss_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  iss_t own_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(string n, bit r, bit [1:0] v, bit [6:0] t0, bit [6:0] t1,
                              bit rdy, bit dv, bit [6:0] rt, bit cv, bit [1:0] rr,
                              bit eg, bit [1:0] rv, bit err, int outs);
    vec_t x;
    x.name = n; x.rst = r; x.v = v; x.t0 = t0; x.t1 = t1; x.rdy = rdy; x.dv = dv;
    x.rt = rt; x.cv = cv; x.rr = rr; x.eg = eg; x.rv = rv; x.err = err; x.outs = outs;
    return x;
  endfunction

  function automatic logic [134:0] fields(int i, logic [6:0] t);
    logic [48:0] a;
    logic [63:0] w;
    a = (49'(i + 1) << 40) | 49'(t);
    w = {16'hC0DE, 8'(i), 33'd0, t};
    return {t, 5'(i + 3), a, w, 8'(8'h0F << i), 2'(i + 1)};
  endfunction

  function automatic logic [63:0] rdata_of(logic [6:0] t);
    return 64'hFEED_0000_0000_0000 | 64'(t);
  endfunction

  task automatic set_req(int i, logic [6:0] t);
    req_tid[i*TW +: TW]   = t;
    req_op[i*5 +: 5]      = 5'(i + 3);
    req_addr[i*AW +: AW]  = (49'(i + 1) << 40) | 49'(t);
    req_wdata[i*DW +: DW] = {16'hC0DE, 8'(i), 33'd0, t};
    req_be[i*8 +: 8]      = 8'(8'h0F << i);
    req_size[i*2 +: 2]    = 2'(i + 1);
  endtask

  task automatic set_rsp(bit dv, logic [6:0] t);
    dc_valid  = dv;
    rsp_tid   = t;
    rsp_rdata = rdata_of(t);
  endtask

  task automatic chk(string nm, logic [191:0] act, logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(vec_t x);
    vec_t e;
    @(posedge clk); #1;
    rst = x.rst; req_valid = x.v; dc_ready = x.rdy;
    set_req(0, x.t0); set_req(1, x.t1);
    set_rsp(x.dv, x.rt);
    exp_q.push_back(x);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({e.name, ".core_valid"}, 192'(core_valid), 192'(e.cv));
    chk({e.name, ".req_ready"}, 192'(req_ready), 192'(e.rr));
    chk({e.name, ".dc_fields"}, 192'({dc_tid, dc_op, dc_addr, dc_wdata, dc_be, dc_size}),
        192'(fields(int'(e.eg), e.eg ? e.t1 : e.t0)));
    chk({e.name, ".resp_valid"}, 192'(resp_valid), 192'(e.rv));
    chk({e.name, ".rsp_err"}, 192'(rsp_err), 192'(e.err));
    chk({e.name, ".outstanding"}, 192'(outstanding), 192'(e.outs));
    if (e.dv) chk({e.name, ".resp_bus"}, 192'({resp_tid, resp_data}), 192'({e.rt, rdata_of(e.rt)}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = '0; dc_ready = 1'b0;
    set_req(0, 7'h00); set_req(1, 7'h00);
    set_rsp(1'b0, 7'h00);
    repeat (2) @(posedge clk);

    //           name        rst  v      t0     t1     rdy   dv    rt     cv    rr     eg    rv     err  outs
    vecs.push_back(mk("rst",    1'b0, 2'b00, 7'h00, 7'h00, 1'b0, 1'b0, 7'h00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 0));
    vecs.push_back(mk("rot0",   1'b0, 2'b11, 7'h01, 7'h02, 1'b1, 1'b0, 7'h00, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 0));
    vecs.push_back(mk("rot1",   1'b0, 2'b10, 7'h01, 7'h02, 1'b1, 1'b0, 7'h00, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0, 1));
    vecs.push_back(mk("rot2",   1'b0, 2'b11, 7'h03, 7'h04, 1'b1, 1'b0, 7'h00, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2));
    vecs.push_back(mk("rot3",   1'b0, 2'b10, 7'h03, 7'h04, 1'b1, 1'b0, 7'h00, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0, 3));
    vecs.push_back(mk("rot4",   1'b0, 2'b00, 7'h00, 7'h00, 1'b1, 1'b0, 7'h00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 4));
    vecs.push_back(mk("lock0",  1'b0, 2'b10, 7'h11, 7'h10, 1'b0, 1'b0, 7'h00, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 4));
    vecs.push_back(mk("lock1",  1'b0, 2'b11, 7'h11, 7'h10, 1'b0, 1'b0, 7'h00, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 4));
    vecs.push_back(mk("lock2",  1'b0, 2'b11, 7'h11, 7'h10, 1'b0, 1'b0, 7'h00, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 4));
    vecs.push_back(mk("lock3",  1'b0, 2'b11, 7'h11, 7'h10, 1'b1, 1'b0, 7'h00, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0, 4));
    vecs.push_back(mk("lock4",  1'b0, 2'b11, 7'h11, 7'h10, 1'b1, 1'b0, 7'h00, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 5));
    vecs.push_back(mk("lock5",  1'b0, 2'b00, 7'h00, 7'h00, 1'b1, 1'b0, 7'h00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 6));
    vecs.push_back(mk("reuse0", 1'b0, 2'b01, 7'h05, 7'h00, 1'b1, 1'b0, 7'h00, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 6));
    vecs.push_back(mk("reuse1", 1'b0, 2'b01, 7'h05, 7'h00, 1'b1, 1'b0, 7'h00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 7));
    vecs.push_back(mk("reuse2", 1'b0, 2'b01, 7'h05, 7'h00, 1'b1, 1'b1, 7'h05, 1'b0, 2'b00, 1'b0, 2'b01, 1'b0, 7));
    vecs.push_back(mk("reuse3", 1'b0, 2'b01, 7'h05, 7'h00, 1'b1, 1'b0, 7'h00, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 6));
    vecs.push_back(mk("lim0",   1'b0, 2'b10, 7'h00, 7'h12, 1'b1, 1'b0, 7'h00, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0, 7));
    vecs.push_back(mk("lim1",   1'b0, 2'b11, 7'h13, 7'h14, 1'b1, 1'b0, 7'h00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 8));
    vecs.push_back(mk("lim2",   1'b0, 2'b11, 7'h13, 7'h14, 1'b1, 1'b1, 7'h02, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 8));
    vecs.push_back(mk("lim3",   1'b0, 2'b11, 7'h13, 7'h14, 1'b1, 1'b0, 7'h00, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 7));
    vecs.push_back(mk("lim4",   1'b0, 2'b10, 7'h00, 7'h14, 1'b1, 1'b1, 7'h12, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 8));
    vecs.push_back(mk("lim5",   1'b0, 2'b10, 7'h00, 7'h14, 1'b1, 1'b0, 7'h00, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0, 7));
    vecs.push_back(mk("sim0",   1'b0, 2'b00, 7'h00, 7'h00, 1'b1, 1'b1, 7'h01, 1'b0, 2'b00, 1'b0, 2'b01, 1'b0, 8));
    vecs.push_back(mk("sim1",   1'b0, 2'b10, 7'h00, 7'h21, 1'b1, 1'b0, 7'h00, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0, 7));
    vecs.push_back(mk("sim2",   1'b0, 2'b00, 7'h00, 7'h00, 1'b1, 1'b1, 7'h03, 1'b0, 2'b00, 1'b0, 2'b01, 1'b0, 8));
    vecs.push_back(mk("sim3",   1'b0, 2'b01, 7'h20, 7'h00, 1'b1, 1'b1, 7'h21, 1'b1, 2'b01, 1'b0, 2'b10, 1'b0, 7));
    vecs.push_back(mk("sim4",   1'b0, 2'b01, 7'h20, 7'h00, 1'b1, 1'b0, 7'h00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 7));
    vecs.push_back(mk("sim5",   1'b0, 2'b10, 7'h00, 7'h21, 1'b1, 1'b0, 7'h00, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0, 7));
    vecs.push_back(mk("err0",   1'b0, 2'b00, 7'h00, 7'h00, 1'b1, 1'b1, 7'h33, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 8));
    vecs.push_back(mk("err1",   1'b0, 2'b00, 7'h00, 7'h00, 1'b1, 1'b0, 7'h00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 8));
    vecs.push_back(mk("mrst0",  1'b1, 2'b00, 7'h00, 7'h00, 1'b1, 1'b0, 7'h00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 8));
    vecs.push_back(mk("mrst1",  1'b0, 2'b00, 7'h00, 7'h00, 1'b1, 1'b0, 7'h00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 0));
    vecs.push_back(mk("mrst2",  1'b0, 2'b00, 7'h00, 7'h00, 1'b1, 1'b1, 7'h04, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 0));
    vecs.push_back(mk("mrst3",  1'b0, 2'b11, 7'h04, 7'h05, 1'b1, 1'b0, 7'h00, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 0));
    vecs.push_back(mk("drop0",  1'b0, 2'b10, 7'h00, 7'h06, 1'b0, 1'b0, 7'h00, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 1));
    vecs.push_back(mk("drop1",  1'b0, 2'b01, 7'h07, 7'h00, 1'b1, 1'b0, 7'h00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1));
    vecs.push_back(mk("drop2",  1'b0, 2'b01, 7'h07, 7'h00, 1'b1, 1'b0, 7'h00, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 1));

    foreach (vecs[n]) apply(vecs[n]);

    // Fill to the limit with alternating owners, then retire in reverse order.
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0; set_rsp(1'b0, 7'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < MO; k++) begin
      bit seen;
      int r;
      r = k % 2;
      @(posedge clk); #1;
      req_valid = 2'(1 << r); dc_ready = 1'b1;
      set_req(r, 7'(7'h40 + k)); set_req(1 - r, 7'h00);
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        if (req_ready[r]) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin
        n_bad++;
        $display("FAIL fill.accept[%0d]: got no req_ready expected req_ready[%0d]=1 within 10 cycles", k, r);
      end else begin
        own_q.push_back('{owner: r, tid: 7'(7'h40 + k)});
      end
    end
    @(posedge clk); #1;
    req_valid = 2'b01; set_req(0, 7'h48);
    @(negedge clk);
    chk("fill.blocked", 192'(core_valid), 192'(0));
    chk("fill.count", 192'(outstanding), 192'(MO));
    @(posedge clk); #1;
    req_valid = '0;
    while (own_q.size() > 0) begin
      iss_t it;
      it = own_q.pop_back();
      @(posedge clk); #1;
      set_rsp(1'b1, it.tid);
      @(negedge clk);
      chk($sformatf("drain.route[%0h]", it.tid), 192'(resp_valid), 192'(1 << it.owner));
      chk($sformatf("drain.err[%0h]", it.tid), 192'(rsp_err), 192'(0));
    end
    @(posedge clk); #1;
    set_rsp(1'b0, 7'h00);
    @(negedge clk);
    chk("drain.count", 192'(outstanding), 192'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
